// File: rtl/smf_pkg.sv
// Shared types and constants for the switching median filter front-end.
// Window taps are numbered row-major: X0 = top-left ... X8 = bottom-right.
package smf_pkg;

    localparam int unsigned PIX_W = 8;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        FLUSH,
        DONE
    } seq_state_t;

    typedef logic [8:0][PIX_W-1:0] window_t;

    localparam int unsigned X0 = 0;
    localparam int unsigned X1 = 1;
    localparam int unsigned X2 = 2;
    localparam int unsigned X3 = 3;
    localparam int unsigned X4 = 4;
    localparam int unsigned X5 = 5;
    localparam int unsigned X6 = 6;
    localparam int unsigned X7 = 7;
    localparam int unsigned X8 = 8;

    // Row slots inside one captured 3-pixel column.
    localparam int unsigned TAP_T = 0;
    localparam int unsigned TAP_M = 1;
    localparam int unsigned TAP_B = 2;

endpackage

// File: rtl/smf_line_buffer.sv
// Fixed-length pixel delay line: tap returns the pixel shifted in DEPTH shifts ago.
// Read-before-write on a single circular address keeps it to one RAM port per cycle.
module smf_line_buffer #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic [PIX_W-1:0] pix,
    output logic [PIX_W-1:0] tap
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PIX_W-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr;

    assign tap = mem[ptr];

    always_ff @(posedge clk) begin
        if (shift) begin
            mem[ptr] <= pix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (shift) begin
            ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
        end
    end

endmodule

// File: rtl/smf_window_sequencer.sv
// Raster-stream to 3x3 replicate-padded window sequencer with fill/run/flush framing.
// Windows trail the input by a constant IMG_W+1 steps; edge columns/rows are fixed by clamping muxes.
module smf_window_sequencer #(
    parameter int unsigned PIX_W = smf_pkg::PIX_W,
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 64
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [PIX_W-1:0]   Pix_In,
    input  logic               Pix_Valid,
    output logic               Pix_Ready,
    output logic [9*PIX_W-1:0] Win,
    output logic               Win_Valid,
    input  logic               Win_Ready,
    output logic [15:0]        Win_Row,
    output logic [15:0]        Win_Col,
    output logic               Frame_Done
);

    import smf_pkg::*;

    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    seq_state_t state;

    logic [CW-1:0] in_col;
    logic [RW-1:0] in_row;
    logic [CW-1:0] out_col;
    logic [RW-1:0] out_row;
    logic          flush_end;

    logic [2:0][PIX_W-1:0]      col_a;
    logic [2:0][PIX_W-1:0]      col_b;
    logic [2:0][PIX_W-1:0]      col_n;
    logic [2:0][2:0][PIX_W-1:0] sel;
    logic [8:0][PIX_W-1:0]      win_d;

    logic [PIX_W-1:0] lb1_tap;
    logic [PIX_W-1:0] lb2_tap;

    logic adv;
    logic pix_take;
    logic flush_step;
    logic step;
    logic emit;

    assign adv        = !Win_Valid || Win_Ready;
    assign Pix_Ready  = !Rst && (state == FILL || state == RUN) && adv;
    assign pix_take   = Pix_Valid && Pix_Ready;
    assign flush_step = !Rst && (state == FLUSH) && adv && !flush_end;
    assign step       = pix_take || flush_step;
    assign emit       = (state == RUN && pix_take) || flush_step;

    smf_line_buffer #(
        .PIX_W (PIX_W),
        .DEPTH (IMG_W)
    ) u_lb1 (
        .clk   (Clk),
        .rst   (Rst),
        .shift (step),
        .pix   (Pix_In),
        .tap   (lb1_tap)
    );

    smf_line_buffer #(
        .PIX_W (PIX_W),
        .DEPTH (IMG_W)
    ) u_lb2 (
        .clk   (Clk),
        .rst   (Rst),
        .shift (step),
        .pix   (lb1_tap),
        .tap   (lb2_tap)
    );

    // Column entering now spans rows r-1..r+1 of the pending centre; during flush the bottom slot is junk.
    always_comb begin
        col_n        = '0;
        col_n[TAP_T] = lb2_tap;
        col_n[TAP_M] = lb1_tap;
        col_n[TAP_B] = Pix_In;
    end

    always_comb begin
        sel    = '0;
        sel[0] = (out_col == '0) ? col_b : col_a;
        sel[1] = col_b;
        sel[2] = (out_col == COL_LAST) ? col_b : col_n;
        win_d  = '0;
        for (int unsigned j = 0; j < 3; j++) begin
            win_d[X0 + j] = (out_row == '0) ? sel[j][TAP_M] : sel[j][TAP_T];
            win_d[X3 + j] = sel[j][TAP_M];
            win_d[X6 + j] = (out_row == ROW_LAST) ? sel[j][TAP_M] : sel[j][TAP_B];
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= FILL;
            in_col     <= '0;
            in_row     <= '0;
            out_col    <= '0;
            out_row    <= '0;
            flush_end  <= 1'b0;
            col_a      <= '0;
            col_b      <= '0;
            Win        <= '0;
            Win_Valid  <= 1'b0;
            Win_Row    <= '0;
            Win_Col    <= '0;
            Frame_Done <= 1'b0;
        end else begin
            Frame_Done <= 1'b0;

            if (step) begin
                col_a <= col_b;
                col_b <= col_n;
            end

            if (pix_take) begin
                if (in_col == COL_LAST) begin
                    in_col <= '0;
                    in_row <= in_row + RW'(1);
                end else begin
                    in_col <= in_col + CW'(1);
                end
            end

            if (emit) begin
                Win       <= win_d;
                Win_Row   <= 16'(out_row);
                Win_Col   <= 16'(out_col);
                Win_Valid <= 1'b1;
                if (out_col == COL_LAST) begin
                    out_col <= '0;
                    out_row <= out_row + RW'(1);
                end else begin
                    out_col <= out_col + CW'(1);
                end
            end else if (Win_Ready) begin
                Win_Valid <= 1'b0;
            end

            case (state)
                FILL: begin
                    if (pix_take && in_row == RW'(1) && in_col == '0) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (pix_take && in_row == ROW_LAST && in_col == COL_LAST) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (flush_step && out_row == ROW_LAST && out_col == COL_LAST) begin
                        flush_end <= 1'b1;
                    end
                    if (flush_end && Win_Valid && Win_Ready) begin
                        state      <= DONE;
                        Frame_Done <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= FILL;
                    in_col    <= '0;
                    in_row    <= '0;
                    out_col   <= '0;
                    out_row   <= '0;
                    flush_end <= 1'b0;
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_smf_window_sequencer.sv
// Scoreboard bench: three sequencer instances (4x4, 8x5, 3x3) driven one at a time from one process.
// Expected windows come from a clamp-to-edge model of the image and are popped as windows transfer.
module tb_smf_window_sequencer;

    import smf_pkg::*;

    typedef struct {
        int           d;
        int           r;
        int           c;
        logic [71:0]  w;
        bit           last;
    } item_t;

    logic       clk = 1'b0;
    logic       rst        [3];
    logic [7:0] pix_in     [3];
    logic       pix_valid  [3];
    logic       pix_ready  [3];
    window_t    win        [3];
    logic       win_valid  [3];
    logic       win_ready  [3];
    logic [15:0] win_row   [3];
    logic [15:0] win_col   [3];
    logic       frame_done [3];

    int iw [3] = '{4, 8, 3};
    int ih [3] = '{4, 5, 3};

    logic [7:0] img [64];
    item_t      sb  [$];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    int      fd_count  [3];
    int      last_cyc  [3];
    bit      took      [3];
    bit      rst_prev  [3];
    bit      hold_prev [3];
    bit      fd_prev   [3];
    window_t hold_win  [3];
    logic [15:0] hold_row [3];
    logic [15:0] hold_col [3];

    always #5 clk = ~clk;

    smf_window_sequencer #(.PIX_W(8), .IMG_W(4), .IMG_H(4)) u_dut0 (
        .Clk(clk), .Rst(rst[0]), .Pix_In(pix_in[0]), .Pix_Valid(pix_valid[0]), .Pix_Ready(pix_ready[0]),
        .Win(win[0]), .Win_Valid(win_valid[0]), .Win_Ready(win_ready[0]),
        .Win_Row(win_row[0]), .Win_Col(win_col[0]), .Frame_Done(frame_done[0])
    );

    smf_window_sequencer #(.PIX_W(8), .IMG_W(8), .IMG_H(5)) u_dut1 (
        .Clk(clk), .Rst(rst[1]), .Pix_In(pix_in[1]), .Pix_Valid(pix_valid[1]), .Pix_Ready(pix_ready[1]),
        .Win(win[1]), .Win_Valid(win_valid[1]), .Win_Ready(win_ready[1]),
        .Win_Row(win_row[1]), .Win_Col(win_col[1]), .Frame_Done(frame_done[1])
    );

    smf_window_sequencer #(.PIX_W(8), .IMG_W(3), .IMG_H(3)) u_dut2 (
        .Clk(clk), .Rst(rst[2]), .Pix_In(pix_in[2]), .Pix_Valid(pix_valid[2]), .Pix_Ready(pix_ready[2]),
        .Win(win[2]), .Win_Valid(win_valid[2]), .Win_Ready(win_ready[2]),
        .Win_Row(win_row[2]), .Win_Col(win_col[2]), .Frame_Done(frame_done[2])
    );

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] model_win(int w, int h, int r, int c);
        logic [71:0] v;
        int rr;
        int cc;
        v = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                rr = r + i - 1;
                cc = c + j - 1;
                if (rr < 0) rr = 0;
                if (rr > h - 1) rr = h - 1;
                if (cc < 0) cc = 0;
                if (cc > w - 1) cc = w - 1;
                v[8*(3*i+j) +: 8] = img[rr*w + cc];
            end
        end
        return v;
    endfunction

    task automatic fill_img(input int w, input int h, input bit rnd);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                img[r*w + c] = rnd ? 8'($urandom_range(255)) : 8'(16*r + c);
            end
        end
    endtask

    task automatic push_frame(input int d, input int count);
        item_t e;
        for (int k = 0; k < count; k++) begin
            e.d    = d;
            e.r    = k / iw[d];
            e.c    = k % iw[d];
            e.w    = model_win(iw[d], ih[d], e.r, e.c);
            e.last = (e.r == ih[d] - 1) && (e.c == iw[d] - 1);
            sb.push_back(e);
        end
    endtask

    task automatic monitor();
        item_t e;
        for (int d = 0; d < 3; d++) begin
            took[d] = 1'b0;
            if (rst[d]) begin
                chk("rst_pix_ready", 72'(pix_ready[d]), 72'(0));
            end else begin
                if (rst_prev[d]) begin
                    chk("reset_pix_ready", 72'(pix_ready[d]), 72'(1));
                    chk("reset_win_valid", 72'(win_valid[d]), 72'(0));
                    chk("reset_win", win[d], 72'(0));
                    chk("reset_row_col", 72'({win_row[d], win_col[d]}), 72'(0));
                    chk("reset_frame_done", 72'(frame_done[d]), 72'(0));
                end
                if (hold_prev[d]) begin
                    chk("hold_valid", 72'(win_valid[d]), 72'(1));
                    chk("hold_win", win[d], hold_win[d]);
                    chk("hold_row", 72'(win_row[d]), 72'(hold_row[d]));
                    chk("hold_col", 72'(win_col[d]), 72'(hold_col[d]));
                end
                if (win_valid[d] && !win_ready[d]) begin
                    chk("stall_pix_ready", 72'(pix_ready[d]), 72'(0));
                end
                if (fd_prev[d] && pix_valid[d]) begin
                    chk("after_done_accept", 72'(pix_ready[d]), 72'(1));
                end
                if (frame_done[d]) begin
                    fd_count[d]++;
                    chk("done_latency", 72'(cyc), 72'(last_cyc[d] + 1));
                    chk("done_pix_ready", 72'(pix_ready[d]), 72'(0));
                end
                if (win_valid[d] && win_ready[d]) begin
                    chk("sb_not_empty", 72'(sb.size() != 0), 72'(1));
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("win_inst", 72'(d), 72'(e.d));
                        chk("win_row", 72'(win_row[d]), 72'(e.r));
                        chk("win_col", 72'(win_col[d]), 72'(e.c));
                        chk("win_data", win[d], e.w);
                        if (e.last) last_cyc[d] = cyc;
                        if (d == 0 && win_row[d] == 16'd1 && win_col[d] == 16'd1)
                            chk("centre_11", win[d], 72'h222120121110020100);
                        if (d == 0 && win_row[d] == 16'd0 && win_col[d] == 16'd0)
                            chk("corner_00", win[d], 72'h111010010000010000);
                        if (d == 0 && win_row[d] == 16'd3 && win_col[d] == 16'd3)
                            chk("corner_33", win[d], 72'h333332333332232322);
                    end
                end
                took[d] = pix_valid[d] && pix_ready[d];
            end
            hold_prev[d] = !rst[d] && win_valid[d] && !win_ready[d];
            hold_win[d]  = win[d];
            hold_row[d]  = win_row[d];
            hold_col[d]  = win_col[d];
            fd_prev[d]   = !rst[d] && frame_done[d];
            rst_prev[d]  = rst[d];
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run(input int d, input int npix, input int vpct, input int rpct,
                       input int stall_at, input int stall_len);
        int  idx = 0;
        int  n = 0;
        int  stall_cnt = 0;
        bit  stalled = 1'b0;
        int  fpix = iw[d] * ih[d];
        while (!(idx >= npix && sb.size() == 0) && n < 3000) begin
            pix_valid[d] = (idx < npix) && (int'($urandom_range(99)) < vpct);
            pix_in[d]    = img[idx % fpix];
            if (!stalled && stall_len > 0 && idx == stall_at) begin
                stalled   = 1'b1;
                stall_cnt = stall_len;
            end
            if (stall_cnt > 0) begin
                win_ready[d] = 1'b0;
                stall_cnt--;
            end else begin
                win_ready[d] = (int'($urandom_range(99)) < rpct);
            end
            cycle();
            if (took[d]) idx++;
            n++;
        end
        chk("run_within_budget", 72'(n < 3000), 72'(1));
        pix_valid[d] = 1'b0;
        win_ready[d] = 1'b1;
        repeat (3) cycle();
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d]       = 1'b1;
            pix_in[d]    = '0;
            pix_valid[d] = 1'b0;
            win_ready[d] = 1'b1;
            fd_count[d]  = 0;
            last_cyc[d]  = -10;
            took[d]      = 1'b0;
            rst_prev[d]  = 1'b0;
            hold_prev[d] = 1'b0;
            fd_prev[d]   = 1'b0;
        end
        repeat (3) cycle();
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        cycle();

        // Plain 4x4 frame at full throughput.
        fill_img(4, 4, 1'b0);
        push_frame(0, 16);
        run(0, 16, 100, 100, -1, 0);
        chk("t1_frame_done", 72'(fd_count[0]), 72'(1));

        // Same frame with a 5-cycle downstream stall mid-run.
        push_frame(0, 16);
        run(0, 16, 100, 100, 8, 5);
        chk("stall_frame_done", 72'(fd_count[0]), 72'(2));

        // Abort after 9 pixels, then a clean frame.
        push_frame(0, 4);
        run(0, 9, 100, 100, -1, 0);
        rst[0] = 1'b1;
        cycle();
        rst[0] = 1'b0;
        cycle();
        chk("abort_no_done", 72'(fd_count[0]), 72'(2));
        push_frame(0, 16);
        run(0, 16, 100, 100, -1, 0);
        chk("after_abort_done", 72'(fd_count[0]), 72'(3));

        // 8x5 random image with random valid gaps and random backpressure.
        fill_img(8, 5, 1'b1);
        push_frame(1, 40);
        run(1, 40, 50, 60, -1, 0);
        chk("rand_frame_done", 72'(fd_count[1]), 72'(1));

        // Two back-to-back 3x3 frames with Pix_Valid held high.
        fill_img(3, 3, 1'b0);
        push_frame(2, 9);
        push_frame(2, 9);
        run(2, 18, 100, 100, -1, 0);
        chk("b2b_frame_done", 72'(fd_count[2]), 72'(2));
        chk("sb_drained", 72'(sb.size()), 72'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
